// File: rtl/crop_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : crop_window_ctrl
// Description : Crop window controller. It accepts a window request, checks
//               and clamps it against the active frame, and applies it at the
//               next frame sync so the window never changes mid-frame.
//               Optional macro CROP_PAN_EN adds per-frame pan of the window.
// Revision    : 1.0 - initial release
// ============================================================================
module crop_window_ctrl #(
  parameter int H_DISP = 1920,
  parameter int V_DISP = 1080,
  parameter int X_W    = 11,
  parameter int Y_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_i,
`ifdef CROP_PAN_EN
  input  logic              pan_en,
  input  logic signed [3:0] pan_dx,
  input  logic signed [3:0] pan_dy,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [X_W-1:0]    cfg_x,
  input  logic [Y_W-1:0]    cfg_y,
  input  logic [11:0]       cfg_w,
  input  logic [11:0]       cfg_h,
  output logic [X_W-1:0]    start_x,
  output logic [Y_W-1:0]    start_y,
  output logic [X_W-1:0]    end_x,
  output logic [Y_W-1:0]    end_y,
  output logic              apply_pulse,
  output logic              cfg_err,
  output logic              clamp_flag
);

  // End sums are at least 13 bits wide so start + width can never wrap.
  localparam int SXW = ((X_W > 12) ? X_W : 12) + 1;
  localparam int SYW = ((Y_W > 12) ? Y_W : 12) + 1;
  localparam logic [SXW-1:0] H_LIM = SXW'(H_DISP);
  localparam logic [SYW-1:0] V_LIM = SYW'(V_DISP);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CHECK   = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_APPLY   = 2'd3;

  logic [1:0]     state;
  logic [1:0]     next_state;
  logic           vs_d;
  logic           vs_rise;
  logic [X_W-1:0] req_x;
  logic [Y_W-1:0] req_y;
  logic [11:0]    req_w;
  logic [11:0]    req_h;
  logic [X_W-1:0] shadow_end_x;
  logic [Y_W-1:0] shadow_end_y;
  logic [SXW-1:0] sum_x;
  logic [SYW-1:0] sum_y;
  logic [SXW-1:0] lim_x;
  logic [SYW-1:0] lim_y;
  logic           over_x;
  logic           over_y;
  logic           reject;
  logic           pan_pulse;
  logic           unused_sum_bits;

  assign vs_rise = vs_i & ~vs_d;
  assign sum_x   = SXW'(req_x) + SXW'(req_w);
  assign sum_y   = SYW'(req_y) + SYW'(req_h);
  assign over_x  = (sum_x > H_LIM);
  assign over_y  = (sum_y > V_LIM);
  assign lim_x   = over_x ? H_LIM : sum_x;
  assign lim_y   = over_y ? V_LIM : sum_y;
  assign reject  = (req_w == 12'd0) || (req_h == 12'd0) ||
                   (SXW'(req_x) >= H_LIM) || (SYW'(req_y) >= V_LIM);
  assign unused_sum_bits = ^{lim_x[SXW-1:X_W], lim_y[SYW-1:Y_W]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic: a request in CHECK always waits for a later frame sync.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (cfg_valid) next_state = ST_CHECK;
      ST_CHECK:   next_state = reject ? ST_IDLE : ST_PENDING;
      ST_PENDING: if (vs_rise) next_state = ST_APPLY;
      ST_APPLY:   next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Output decode from state (plus the pan strobe when panning is built in).
  always_comb begin
    cfg_ready   = (state == ST_IDLE);
    apply_pulse = (state == ST_APPLY) | pan_pulse;
  end

  // Frame sync edge detector; a long vs_i high produces one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vs_d <= 1'b0;
    else     vs_d <= vs_i;
  end

  // Capture request fields on the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_x <= '0;
      req_y <= '0;
      req_w <= '0;
      req_h <= '0;
    end else if (cfg_valid && cfg_ready) begin
      req_x <= cfg_x;
      req_y <= cfg_y;
      req_w <= cfg_w;
      req_h <= cfg_h;
    end
  end

  // Validate and clamp the request; strobes are registered one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err      <= 1'b0;
      clamp_flag   <= 1'b0;
      shadow_end_x <= X_W'(H_DISP);
      shadow_end_y <= Y_W'(V_DISP);
    end else begin
      cfg_err    <= 1'b0;
      clamp_flag <= 1'b0;
      if (state == ST_CHECK) begin
        if (reject) begin
          cfg_err <= 1'b1;
        end else begin
          shadow_end_x <= lim_x[X_W-1:0];
          shadow_end_y <= lim_y[Y_W-1:0];
          clamp_flag   <= over_x | over_y;
        end
      end
    end
  end

`ifdef CROP_PAN_EN
  localparam int PXW = X_W + 2;
  localparam int PYW = Y_W + 2;

  logic                  pan_go;
  logic [X_W-1:0]        win_w;
  logic [Y_W-1:0]        win_h;
  logic signed [PXW-1:0] pan_raw_x;
  logic signed [PXW-1:0] pan_max_x;
  logic signed [PYW-1:0] pan_raw_y;
  logic signed [PYW-1:0] pan_max_y;
  logic [X_W-1:0]        pan_sx;
  logic [Y_W-1:0]        pan_sy;
  logic                  unused_pan_bits;

  assign pan_go = (state == ST_IDLE) && vs_rise && pan_en;
  assign unused_pan_bits = ^{pan_raw_x[PXW-2:X_W], pan_max_x[PXW-1:X_W],
                             pan_raw_y[PYW-2:Y_W], pan_max_y[PYW-1:Y_W]};

  // Shifted start, clamped so the window keeps its size inside the frame.
  always_comb begin
    win_w     = end_x - start_x;
    win_h     = end_y - start_y;
    pan_raw_x = $signed({2'b00, start_x}) + PXW'(pan_dx);
    pan_max_x = PXW'(H_DISP) - $signed({2'b00, win_w});
    pan_raw_y = $signed({2'b00, start_y}) + PYW'(pan_dy);
    pan_max_y = PYW'(V_DISP) - $signed({2'b00, win_h});
    if (pan_raw_x[PXW-1])           pan_sx = '0;
    else if (pan_raw_x > pan_max_x) pan_sx = pan_max_x[X_W-1:0];
    else                            pan_sx = pan_raw_x[X_W-1:0];
    if (pan_raw_y[PYW-1])           pan_sy = '0;
    else if (pan_raw_y > pan_max_y) pan_sy = pan_max_y[Y_W-1:0];
    else                            pan_sy = pan_raw_y[Y_W-1:0];
  end

  // Pan strobe accompanies the window update it caused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pan_pulse <= 1'b0;
    else     pan_pulse <= pan_go;
  end
`else
  assign pan_pulse = 1'b0;
`endif

  // Window outputs move only at a frame sync (request apply or pan step).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_x <= '0;
      start_y <= '0;
      end_x   <= X_W'(H_DISP);
      end_y   <= Y_W'(V_DISP);
    end else if ((state == ST_PENDING) && vs_rise) begin
      start_x <= req_x;
      start_y <= req_y;
      end_x   <= shadow_end_x;
      end_y   <= shadow_end_y;
    end
`ifdef CROP_PAN_EN
    else if (pan_go) begin
      start_x <= pan_sx;
      start_y <= pan_sy;
      end_x   <= pan_sx + win_w;
      end_y   <= pan_sy + win_h;
    end
`endif
  end

endmodule
`default_nettype wire
